// File: rtl/seq_approx_divider.sv
// Iterative restoring divider: one quotient bit per clock behind a start/done handshake.
// The last APPROX_ROWS rows can run in approximate mode, where the truncated LSB cells pass the remainder through.
module seq_approx_divider #(
    parameter int unsigned N           = 8,
    parameter int unsigned APPROX_ROWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             approx_en_i,
    input  logic [2*N-1:0]   x_i,
    input  logic [N-1:0]     y_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [N-1:0]     q_o,
    output logic [N-1:0]     r_o,
    output logic             ovf_o
);

    localparam int unsigned CNT_W     = $clog2(N);
    localparam int unsigned K_W       = $clog2(N + 1);
    localparam int unsigned FIRST_APX = N - APPROX_ROWS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N-1:0]       rem_q, rem_d;
    logic [N-1:0]       xlo_q, xlo_d;
    logic [N-1:0]       div_q, div_d;
    logic               apx_q, apx_d;
    logic               ovf_lat_q, ovf_lat_d;
    logic [N-1:0]       qsr_q, qsr_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [N-1:0]       q_q, q_d;
    logic [N-1:0]       r_q, r_d;
    logic               ovf_q, ovf_d;

    logic [N:0]         p;
    logic [K_W-1:0]     k;
    logic [N-1:0]       diff;
    logic [N-1:0]       rem_row;
    logic               borrow;
    logic               qs;

    // One divider row: borrow-chain subtract over the exact cells, then quotient-select mux
    always_comb begin
        p      = {rem_q, xlo_q[N-1]};
        k      = '0;
        if (apx_q && (32'(cnt_q) >= FIRST_APX)) begin
            k = K_W'(32'(cnt_q) - FIRST_APX + 32'd1);
        end
        borrow = 1'b0;
        diff   = '0;
        for (int j = 0; j < N; j++) begin
            if (K_W'(j) < k) begin
                // truncated cell: the chain into cell k ends up as y[k-1]
                borrow = div_q[j];
            end else begin
                diff[j] = p[j] ^ div_q[j] ^ borrow;
                borrow  = (~p[j] & borrow) | (~p[j] & div_q[j]) | (div_q[j] & borrow);
            end
        end
        qs      = ~borrow | p[N];
        rem_row = p[N-1:0];
        for (int j = 0; j < N; j++) begin
            if ((K_W'(j) >= k) && qs) begin
                rem_row[j] = diff[j];
            end
        end
    end

    // Sequencing: accept, iterate rows, publish
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        xlo_d     = xlo_q;
        div_d     = div_q;
        apx_d     = apx_q;
        ovf_lat_d = ovf_lat_q;
        qsr_d     = qsr_q;
        done_d    = 1'b0;
        q_d       = q_q;
        r_d       = r_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    rem_d     = x_i[2*N-1:N];
                    xlo_d     = x_i[N-1:0];
                    div_d     = y_i;
                    apx_d     = approx_en_i;
                    ovf_lat_d = (x_i[2*N-1:N] >= y_i);
                    qsr_d     = '0;
                end
            end
            RUN: begin
                rem_d = rem_row;
                xlo_d = {xlo_q[N-2:0], 1'b0};
                qsr_d = {qsr_q[N-2:0], qs};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = DONE;
                    q_d     = {qsr_q[N-2:0], qs};
                    r_d     = rem_row;
                    ovf_d   = ovf_lat_q;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            xlo_q     <= '0;
            div_q     <= '0;
            apx_q     <= 1'b0;
            ovf_lat_q <= 1'b0;
            qsr_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            xlo_q     <= xlo_d;
            div_q     <= div_d;
            apx_q     <= apx_d;
            ovf_lat_q <= ovf_lat_d;
            qsr_q     <= qsr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            q_q       <= q_d;
            r_q       <= r_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign q_o    = q_q;
    assign r_o    = r_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Self-checking bench for seq_approx_divider: directed table, handshake corner cases, randomized ops vs. reference model.
module tb_seq_approx_divider;

    localparam int N  = 8;
    localparam int AR = 4;

    logic         clk;
    logic         rst;
    logic         start_i;
    logic         approx_en_i;
    logic [15:0]  x_i;
    logic [7:0]   y_i;
    logic         busy_o;
    logic         done_o;
    logic [7:0]   q_o;
    logic [7:0]   r_o;
    logic         ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    seq_approx_divider #(.N(N), .APPROX_ROWS(AR)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .approx_en_i (approx_en_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .q_o         (q_o),
        .r_o         (r_o),
        .ovf_o       (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  y;
        bit          apx;
        logic [7:0]  q;
        logic [7:0]  r;
        bit          ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: per row, the kept upper slice P[N-1:k] is compared/subtracted against y[N-1:k] plus the y[k-1] borrow-in
    function automatic void ref_div(input logic [15:0] x, input logic [7:0] y, input bit apx,
                                    output logic [7:0] q, output logic [7:0] r, output bit ovf);
        int  rem, p, k, bin, hi, need, nb;
        bit  qs;
        rem = int'(x[15:8]);
        ovf = (rem >= int'(y));
        q   = '0;
        for (int i = 0; i < N; i++) begin
            p    = (rem << 1) | int'(x[N-1-i]);
            k    = (apx && i >= N - AR) ? i - (N - AR) + 1 : 0;
            bin  = (k > 0) ? int'(y[k-1]) : 0;
            nb   = N - k;
            hi   = (p & 255) >> k;
            need = (int'(y) >> k) + bin;
            qs   = (p >= 256) || (hi >= need);
            if (qs) rem = (((hi - need) & ((1 << nb) - 1)) << k) | (p & ((1 << k) - 1));
            else    rem = p & 255;
            q[N-1-i] = qs;
        end
        r = 8'(rem);
    endfunction

    // Caller is at a negedge; returns at the negedge where done is seen (or after the cycle budget)
    task automatic do_op(input logic [15:0] x, input logic [7:0] y, input bit apx,
                         output logic [7:0] q, output logic [7:0] r, output logic ovf,
                         output int lat, output bit held, output bit bsy_ok);
        logic [7:0] q0, r0;
        int n;
        q0 = q_o; r0 = r_o; held = 1'b1; bsy_ok = 1'b1;
        x_i = x; y_i = y; approx_en_i = apx; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        x_i = 16'($urandom); y_i = 8'($urandom); approx_en_i = 1'($urandom);
        n = 1;
        while (!done_o && n < 40) begin
            if (q_o !== q0 || r_o !== r0) held = 1'b0;
            if (busy_o !== 1'b1) bsy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        if (busy_o !== 1'b0) bsy_ok = 1'b0;
        lat = done_o ? n - 1 : -1;
        q = q_o; r = r_o; ovf = ovf_o;
    endtask

    vec_t        vecs[6];
    logic [7:0]  gq, gr, eq, er;
    logic        govf;
    bit          eovf, held, bsy_ok;
    int          lat, n;
    logic [15:0] rx;
    logic [7:0]  ry;
    bit          rapx;

    initial begin
        vecs[0] = '{x: 16'd1000,   y: 8'd7,  apx: 1'b0, q: 8'd142, r: 8'd6,   ovf: 1'b0};
        vecs[1] = '{x: 16'd4095,   y: 8'd16, apx: 1'b1, q: 8'd255, r: 8'd15,  ovf: 1'b0};
        vecs[2] = '{x: 16'd3,      y: 8'd3,  apx: 1'b1, q: 8'd3,   r: 8'd3,   ovf: 1'b0};
        vecs[3] = '{x: 16'd3,      y: 8'd3,  apx: 1'b0, q: 8'd1,   r: 8'd0,   ovf: 1'b0};
        vecs[4] = '{x: 16'd1000,   y: 8'd0,  apx: 1'b0, q: 8'd255, r: 8'd232, ovf: 1'b1};
        vecs[5] = '{x: 16'h0A00,   y: 8'd5,  apx: 1'b0, q: 8'd255, r: 8'd5,   ovf: 1'b1};

        rst = 1'b1; start_i = 1'b0; approx_en_i = 1'b0; x_i = '0; y_i = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset q",    32'(q_o),    32'd0);
        check("reset r",    32'(r_o),    32'd0);
        check("reset ovf",  32'(ovf_o),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors, launched back-to-back out of DONE
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].x, vecs[i].y, vecs[i].apx, gq, gr, govf, lat, held, bsy_ok);
            check($sformatf("vec%0d q", i),    32'(gq),   32'(vecs[i].q));
            check($sformatf("vec%0d r", i),    32'(gr),   32'(vecs[i].r));
            check($sformatf("vec%0d ovf", i),  32'(govf), 32'(vecs[i].ovf));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
            check($sformatf("vec%0d hold", i), 32'(held), 32'd1);
            check($sformatf("vec%0d busy", i), 32'(bsy_ok), 32'd1);
        end

        // Start during RUN is ignored
        @(negedge clk);
        x_i = 16'd1000; y_i = 8'd7; approx_en_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; n = 1;
        repeat (2) begin @(negedge clk); n++; end
        x_i = 16'h0A00; y_i = 8'd5; start_i = 1'b1;
        @(negedge clk);
        n++; start_i = 1'b0;
        while (!done_o && n < 40) begin @(negedge clk); n++; end
        check("runstart latency", 32'(n - 1), 32'd8);
        check("runstart q",       32'(q_o),   32'd142);
        check("runstart r",       32'(r_o),   32'd6);
        @(negedge clk);
        check("runstart no relaunch done", 32'(done_o), 32'd0);
        check("runstart no relaunch busy", 32'(busy_o), 32'd0);

        // Explicit back-to-back pair: q/r of the first must hold until the second completes
        do_op(16'd1000, 8'd7, 1'b0, gq, gr, govf, lat, held, bsy_ok);
        do_op(16'd4095, 8'd16, 1'b1, gq, gr, govf, lat, held, bsy_ok);
        check("b2b latency", 32'(lat),  32'd8);
        check("b2b hold",    32'(held), 32'd1);
        check("b2b q",       32'(gq),   32'd255);
        check("b2b r",       32'(gr),   32'd15);

        // Reset mid-operation
        @(negedge clk);
        x_i = 16'd1000; y_i = 8'd0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 32'(busy_o), 32'd0);
        check("midrst done", 32'(done_o), 32'd0);
        check("midrst q",    32'(q_o),    32'd0);
        check("midrst r",    32'(r_o),    32'd0);
        check("midrst ovf",  32'(ovf_o),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(16'd1000, 8'd7, 1'b0, gq, gr, govf, lat, held, bsy_ok);
        check("postrst q",       32'(gq),  32'd142);
        check("postrst r",       32'(gr),  32'd6);
        check("postrst latency", 32'(lat), 32'd8);

        // Randomized operations
        for (int t = 0; t < 150; t++) begin
            rx = 16'($urandom); ry = 8'($urandom); rapx = 1'($urandom);
            if ($urandom_range(0, 3) == 0) ry = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) rx[15:8] = 8'(int'(rx[15:8]) % ((ry == 0) ? 1 : int'(ry)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ref_div(rx, ry, rapx, eq, er, eovf);
            do_op(rx, ry, rapx, gq, gr, govf, lat, held, bsy_ok);
            check($sformatf("rand%0d q x=%0d y=%0d a=%0d", t, rx, ry, rapx), 32'(gq), 32'(eq));
            check($sformatf("rand%0d r x=%0d y=%0d a=%0d", t, rx, ry, rapx), 32'(gr), 32'(er));
            check($sformatf("rand%0d ovf", t), 32'(govf), 32'(eovf));
            check($sformatf("rand%0d latency", t), 32'(lat), 32'd8);
            if (!rapx && ry != 0 && rx[15:8] < ry) begin
                check($sformatf("rand%0d exact quotient", t), 32'(gq), 32'(rx / 16'(ry)));
                check($sformatf("rand%0d exact remainder", t), 32'(gr), 32'(rx % 16'(ry)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_approx_divider.md
# seq_approx_divider

Iterative, parametrised restoring divider that resolves one quotient bit per clock. It reuses the row arithmetic of the combinational array divider: borrow-chain subtract, then a quotient-select mux on the remainder. Its final APPROX_ROWS rows can be switched at run time to the approximate cell mode, which has a growing number of truncated LSB cells. It sits behind a start/done handshake in the divider datapath, where area matters more than single-cycle latency.

## Interface
- N, 8: divisor, quotient and remainder width; the dividend is 2N bits. N ≥ 2.
- APPROX_ROWS, 4: number of final iterations eligible for approximation; 0 ≤ APPROX_ROWS ≤ N.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only in IDLE or DONE.
- approx_en  input  1  selects approximate mode; latched with start.
- x  input  2N  dividend; latched with start.
- y  input  N  divisor; latched with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when q/r/ovf become valid.
- q  output  N  quotient; held until the next accepted start completes.
- r  output  N  remainder; held in the same way.
- ovf  output  1  x[2N-1:N] ≥ y (this includes y = 0); valid with done.

## Operation
- FSM has three states: IDLE, RUN, DONE. Reset state is IDLE.
  - IDLE: start = 1 → RUN.
  - RUN: the row counter i runs from 0 to N-1; when the row with i = N-1 completes → DONE.
  - DONE: held for exactly one cycle. start = 1 → RUN (back-to-back operation); otherwise → IDLE.
- On accept, latch the operands and initialise:
  - R = x[2N-1:N], an N-bit partial remainder.
  - ovf_r = (x[2N-1:N] ≥ y).
  - Clear the q shift register.
- Row i:
  - P = {R, x[N-1-i]}, (N+1) bits.
  - Compute k, the number of approximate cells: k = max(0, i − (N − APPROX_ROWS) + 1) if the latched approx_en = 1; otherwise k = 0.
- Exact cells j ≥ k:
  - borrow_out = ~P[j]&b_in | ~P[j]&y[j] | y[j]&b_in
  - diff = P[j]^y[j]^b_in
- Approximate cells j < k:
  - The borrow chain into cell k is y[k-1]; for k = 0 it is the constant 0.
  - Remainder bits P[j] pass through unchanged, regardless of qs.
- Quotient select: qs = ~borrow_out(cell N-1) | P[N].
- New remainder for exact bits: R[j] = qs ? diff[j] : P[j]. For approximate bits j < k: R[j] = P[j].
- qs shifts into q at bit N-1-i. After row N-1, publish q, r = R and ovf.
- No special-casing for ovf or y = 0: the results are whatever the rows produce.
- The dividend LSB chain input (bin) is tied to 0.
- While in RUN, start is ignored; input changes do not affect the operation in flight.

## Timing
- Reset values: busy = 0, done = 0, q = 0, r = 0, ovf = 0, state = IDLE. Reset asserted mid-RUN aborts the operation; the outputs return to their reset values asynchronously.
- Start accepted at edge t:
  - busy = 1 from t to t+N (N cycles).
  - Rows are evaluated at edges t+1 through t+N.
  - q, r and ovf update at edge t+N.
  - done = 1 for the cycle following edge t+N.
- Latency is N cycles from start to done. Throughput is one result per N+1 cycles, or per N cycles with back-to-back starts (start asserted during DONE).
- q, r and ovf are stable from one done until the next done; they do not change during RUN.

## Test plan
- Exact mode, N = 8, approx_en = 0, x = 1000, y = 7 → after 8 cycles: done pulse, q = 142, r = 6, ovf = 0.
- Approx mode is exact when y has zero LSBs: approx_en = 1, x = 4095, y = 16 → q = 255, r = 15, ovf = 0.
- Approx error case: approx_en = 1, x = 3, y = 3 → q = 3, r = 3. The same operands with approx_en = 0 → q = 1, r = 0.
- Divide by zero: x = 1000, y = 0, approx_en = 0 → q = 255, r = 232, ovf = 1. Also x = 0x0A00, y = 5 → ovf = 1.
- Handshake:
  - Start during RUN is ignored.
  - Start during DONE launches a second operation; it yields a done pulse exactly 8 cycles later, and q/r are held between the two results.
- Reset at row 4 of an operation → all outputs are 0 and state is IDLE. A subsequent start with x = 1000, y = 7 produces q = 142, r = 6.
